// File: rtl/output_buffer.sv
// Result buffer: engine writes words by address, start drains words 0..len-1 over valid/ready; OBUF_PARITY_EN adds out_parity.
// First beat 2 cycles after start; 2-deep read-ahead keeps 1 beat/cycle, beats hold stable while out_ready is low.
module output_buffer #(
  parameter int BUFFER_DATA_WIDTH = 16,
  parameter int BUFFER_ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] wr_data,
  input  logic                         start,
  input  logic [BUFFER_ADDR_WIDTH:0]   drain_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err
`ifdef OBUF_PARITY_EN
  ,
  output logic                         out_parity
`endif
);
  localparam int DEPTH = 1 << BUFFER_ADDR_WIDTH;
  localparam int LW    = BUFFER_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t                       r_state, w_state_nxt;
  logic [BUFFER_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]                r_rd_ptr, r_len;
  logic                         r_wr_err;
  logic                         r_q_vld, r_q_last;
  logic [BUFFER_DATA_WIDTH-1:0] r_q_dat;
  logic                         r_out_vld, r_out_last;
  logic [BUFFER_DATA_WIDTH-1:0] r_out_dat;
  logic                         r_sk_vld, r_sk_last;
  logic [BUFFER_DATA_WIDTH-1:0] r_sk_dat;

  logic          w_busy, w_hs, w_room, w_issue, w_adv, w_from_sk, w_from_q;
  logic [1:0]    w_occ;
  logic [LW-1:0] w_len_clip;

  assign w_busy     = (r_state == FETCH) || (r_state == STREAM);
  assign w_hs       = r_out_vld && out_ready;
  assign w_len_clip = (drain_len > LW'(DEPTH)) ? LW'(DEPTH) : drain_len;
  // Words in flight or buffered may not exceed the two output-side slots.
  assign w_occ      = 2'(r_out_vld) + 2'(r_sk_vld) + 2'(r_q_vld);
  assign w_room     = (w_occ < 2'd2) || (w_hs && (w_occ == 2'd2));
  assign w_issue    = w_busy && (r_rd_ptr < r_len) && w_room;
  assign w_adv      = w_hs || !r_out_vld;
  assign w_from_sk  = w_adv && r_sk_vld;
  assign w_from_q   = w_adv && !r_sk_vld && r_q_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (drain_len == '0) ? DONE : FETCH;
      FETCH:   w_state_nxt = STREAM;
      STREAM:  if (w_hs && r_out_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_ptr <= '0;
      r_len    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_wr_err <= 1'b0;
        r_rd_ptr <= '0;
        if (drain_len != '0) r_len <= w_len_clip;
      end else begin
        if (wr_en && (r_state != IDLE)) r_wr_err <= 1'b1;
        if (w_issue) r_rd_ptr <= r_rd_ptr + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (r_state == IDLE)) r_mem[wr_addr] <= wr_data;
    if (w_issue) r_q_dat <= r_mem[r_rd_ptr[BUFFER_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_vld  <= 1'b0;
      r_q_last <= 1'b0;
    end else begin
      r_q_vld <= w_issue;
      if (w_issue) r_q_last <= (r_rd_ptr == (r_len - LW'(1)));
    end
  end

  // Output register refills from the skid entry first, so beats stay in address order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
      r_sk_vld   <= 1'b0;
      r_sk_dat   <= '0;
      r_sk_last  <= 1'b0;
    end else if (w_adv) begin
      if (r_sk_vld) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= r_sk_dat;
        r_out_last <= r_sk_last;
        r_sk_vld   <= r_q_vld;
        r_sk_dat   <= r_q_dat;
        r_sk_last  <= r_q_last;
      end else begin
        r_out_vld  <= r_q_vld;
        r_out_last <= r_q_vld && r_q_last;
        if (r_q_vld) r_out_dat <= r_q_dat;
      end
    end else if (r_q_vld) begin
      r_sk_vld  <= 1'b1;
      r_sk_dat  <= r_q_dat;
      r_sk_last <= r_q_last;
    end
  end

`ifdef OBUF_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_out_par <= 1'b0;
    else if (w_from_sk) r_out_par <= ^r_sk_dat;
    else if (w_from_q)  r_out_par <= ^r_q_dat;
  end

  assign out_parity = r_out_par;
`else
  logic w_unused_sel;
  assign w_unused_sel = w_from_sk ^ w_from_q;
`endif

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_last  = r_out_last;
  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign wr_err    = r_wr_err;
endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: table of drain cases, hand-written corner sequences, random drains vs a memory-array model.
`timescale 1ns/1ps
module tb_output_buffer;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          wr_en = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [LW-1:0] drain_len = '0;
  logic          out_valid, out_last, busy, done, wr_err;
  logic [DW-1:0] out_data;
`ifdef OBUF_PARITY_EN
  logic          out_parity;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic          exp_wr_err = 1'b0;

  typedef struct {
    int len;
    int rmode;
    int exp_beats;
    int exp_first;
    int exp_done;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  output_buffer #(.BUFFER_DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .drain_len(drain_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .wr_err(wr_err)
`ifdef OBUF_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random. Region r=0 is the cycle after the start edge.
  task automatic run_drain(input int len, input int rmode, input int exp_beats, input int exp_first,
                           input int exp_done, input int inj_r, input bit cw_en, input int cw_addr,
                           input logic [DW-1:0] cw_dat);
    logic [DW-1:0] exp_q [$];
    int            nexp, beats, first_r, done_r;
    bit            stalled;
    logic [DW-1:0] held_dat;
    logic          held_last;
    @(posedge clk); #1;
    start = 1'b1; drain_len = LW'(len);
    if (cw_en) begin
      wr_en = 1'b1; wr_addr = AW'(cw_addr); wr_data = cw_dat;
      model_mem[cw_addr] = cw_dat;
    end
    nexp = (len > DEPTH) ? DEPTH : len;
    exp_q = {};
    for (int i = 0; i < nexp; i++) exp_q.push_back(model_mem[i]);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0; exp_wr_err = 1'b0;
    beats = 0; first_r = -1; done_r = -1; stalled = 1'b0;
    held_dat = '0; held_last = 1'b0;
    for (int r = 0; r < 300; r++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((r % 4) == 0) || ((r % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (r == inj_r) begin
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = DW'(16'h00AA);
        start = 1'b1; drain_len = LW'(5);
        exp_wr_err = 1'b1;
      end else if (r == inj_r + 1) begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      if (r == 0) chk("busy_after_start", busy, (len != 0));
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_dat);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (first_r < 0) first_r = r;
        if (beats < exp_q.size()) begin
          chk("beat_data", out_data, exp_q[beats]);
          chk("beat_last", out_last, (beats == exp_q.size() - 1));
`ifdef OBUF_PARITY_EN
          chk("beat_parity", out_parity, ^exp_q[beats]);
`endif
        end
        beats++;
      end
      stalled   = out_valid && !out_ready;
      held_dat  = out_data;
      held_last = out_last;
      if (done) begin
        done_r = r;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen_in_budget", (done_r >= 0), 1);
    chk("beat_count", beats, exp_beats);
    if (exp_first >= 0) chk("first_beat_cycle", first_r, exp_first);
    if (exp_done >= 0) chk("done_cycle", done_r, exp_done);
    chk("done_valid_low", out_valid, 0);
    chk("done_busy_low", busy, 0);
    chk("wr_err", wr_err, exp_wr_err);
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_valid_low", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8,         0, 8,     2,  10};
    vecs[1] = '{8,         1, 8,     -1, -1};
    vecs[2] = '{0,         0, 0,     -1, 0};
    vecs[3] = '{DEPTH + 5, 0, DEPTH, 2,  DEPTH + 2};
    vecs[4] = '{DEPTH,     1, DEPTH, -1, -1};
    vecs[5] = '{1,         0, 1,     2,  3};
    vecs[6] = '{3,         2, 3,     -1, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
`ifdef OBUF_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) write_word(i, DW'(16'h10 + i));

    for (int v = 0; v < 7; v++)
      run_drain(vecs[v].len, vecs[v].rmode, vecs[v].exp_beats, vecs[v].exp_first,
                vecs[v].exp_done, -1, 1'b0, 0, '0);

    // Write and second start during a drain are both ignored; wr_err sticks until the next start.
    run_drain(8, 0, 8, 2, 10, 4, 1'b0, 0, '0);
    run_drain(8, 0, 8, 2, 10, -1, 1'b0, 0, '0);

    // Write in the same cycle as start must be visible to that drain.
    run_drain(4, 0, 4, 2, 6, -1, 1'b1, 2, DW'(16'hBEEF));

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    start = 1'b1; drain_len = LW'(8); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("beat3_before_rst", out_data, model_mem[3]);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    rst = 1'b0;
    write_word(0, DW'(16'h0055));
    write_word(1, DW'(16'h0066));
    run_drain(2, 0, 2, 2, 4, -1, 1'b0, 0, '0);

    for (int it = 0; it < 25; it++) begin
      int nw, len, nexp;
      bit cw;
      nw = int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) write_word(int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      len  = int'($urandom_range(0, DEPTH + 3));
      nexp = (len > DEPTH) ? DEPTH : len;
      cw   = ($urandom_range(0, 3) == 0);
      run_drain(len, int'($urandom_range(1, 2)), nexp, -1, -1, -1, cw,
                int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
